// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, branch redirect, IF/ID handshake and status.
interface fetch_stage_if;
  logic [31:0] pc_out;
  logic [31:0] instr_in;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [15:0] fetch_cnt;
  logic        halted;

  modport master (
    output pc_out, if_valid, if_instr, if_pc, fetch_cnt, halted,
    input  instr_in, branch_taken, branch_target, id_ready
  );

  modport slave (
    input  pc_out, if_valid, if_instr, if_pc, fetch_cnt, halted,
    output instr_in, branch_taken, branch_target, id_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, IF/ID register with valid/ready, branch redirect, accept counter.
// Optional macro FETCH_HALT_EN: an all-ones instruction stops fetch until a branch or reset.
module fetch_stage #(
  parameter int unsigned IMEM_DEPTH = 16,
  parameter int unsigned RESET_PC   = 0
) (
  input logic           clk,
  input logic           rst_n,
  fetch_stage_if.master bus
);

  localparam int unsigned AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int unsigned CW = 16;
  localparam int unsigned DW = 32;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e          r_state, w_state;
  logic [AW-1:0]   r_pc, w_pc;
  logic            r_valid, w_valid;
  logic [DW-1:0]   r_instr, w_instr;
  logic [AW-1:0]   r_ifpc, w_ifpc;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic            w_accept;
  logic            w_advance;
  logic            w_unused_tgt;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_pc    <= AW'(RESET_PC);
      r_valid <= 1'b0;
      r_instr <= '0;
      r_ifpc  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_pc    <= w_pc;
      r_valid <= w_valid;
      r_instr <= w_instr;
      r_ifpc  <= w_ifpc;
      r_cnt   <= w_cnt;
    end
  end

  // Next state: branch beats capture beats stall
  always_comb begin
    w_state   = r_state;
    w_pc      = r_pc;
    w_valid   = r_valid;
    w_instr   = r_instr;
    w_ifpc    = r_ifpc;
    w_cnt     = r_cnt;
    w_accept  = r_valid && bus.id_ready;
    w_advance = (r_state == ST_RUN) && (!r_valid || bus.id_ready);

    if (w_accept && (r_cnt != {CW{1'b1}})) begin
      w_cnt = r_cnt + CW'(1);
    end

    if (bus.branch_taken) begin
      w_pc    = bus.branch_target[AW-1:0];
      w_valid = 1'b0;
      w_state = ST_RUN;
    end else if (w_advance) begin
      w_instr = bus.instr_in;
      w_ifpc  = r_pc;
      w_valid = 1'b1;
      w_pc    = r_pc + AW'(1);
`ifdef FETCH_HALT_EN
      if (bus.instr_in == 32'hFFFF_FFFF) begin
        w_state = ST_HALT;
      end
`endif
    end else if ((r_state == ST_HALT) && w_accept) begin
      // halting instruction consumed; nothing follows it
      w_valid = 1'b0;
    end
  end

  assign w_unused_tgt = ^bus.branch_target[DW-1:AW];

  assign bus.pc_out    = DW'(r_pc);
  assign bus.if_valid  = r_valid;
  assign bus.if_instr  = r_instr;
  assign bus.if_pc     = DW'(r_ifpc);
  assign bus.fetch_cnt = r_cnt;
`ifdef FETCH_HALT_EN
  assign bus.halted    = (r_state == ST_HALT);
`else
  assign bus.halted    = 1'b0;
`endif

endmodule
